gig_eth_tx_frame_gen: RTL
=========================

// Module: gig_eth_tx_frame_gen
// PURPOSE
//  Test-frame source for the MAC TX client interface (drives mac_tx_data/dvld, obeys mac_tx_ack).
//  Emits Ethernet frames for delay measurement: DA, SA, EtherType, 32b sequence, 32b tx timestamp, pad.
//  Sits between run-control logic and the gig_eth_mac TX client port. The MAC appends preamble and CRC.
// PARAMETERS
//  DST_MAC    48'hFFFF_FFFF_FFFF  destination address, sent MSB byte first
//  SRC_MAC    48'h0002_0304_0506  source address, sent MSB byte first
//  ETHERTYPE  16'h88B5            EtherType field
//  MIN_LEN    60                  minimum frame bytes, CRC excluded
//  MAX_LEN    1514                maximum frame bytes, CRC excluded (standard, untagged)
// PORTS
//  tx_clk           in   1   single clock; all logic on its rising edge
//  reset            in   1   asynchronous, active-high reset
//  gen_en           in   1   level; 1 = generate frames
//  gen_len          in   14  frame length in bytes, CRC excluded; sampled at each frame start
//  gen_ifg          in   16  idle cycles between frames (dvld low); sampled at each frame end
//  gen_count        in   32  frames per run; 0 = continuous
//  mac_tx_data      out  8   frame byte to MAC
//  mac_tx_dvld      out  1   byte valid; held high for the whole frame
//  mac_tx_underrun  out  1   tied 0
//  mac_tx_ack       in   1   MAC accepted the first byte
//  gen_busy         out  1   1 in any state other than IDLE and DONE
//  gen_done         out  1   1 in DONE (finite run complete)
//  gen_frames_sent  out  32  frames completed in the current run
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, seq=0, ts_ctr=0. Async assertion drops dvld the same instant, even mid-frame.
//  ts_ctr: 32b free-running cycle counter, incremented every cycle, wraps 2^32-1 -> 0.
//  Frame layout by byte index: 0-5 DA | 6-11 SA | 12-13 EtherType | 14-17 seq (MSB first) |
//    18-21 timestamp (MSB first) | 22..L-1 pad 0x00.
//  L = clamp(gen_len, MIN_LEN, MAX_LEN); sampled on IDLE/IFG -> WAIT_ACK; later gen_len changes don't affect the frame in flight.
//  Handshake: byte 0 is driven with dvld=1 and held until the cycle ack=1. Bytes 1..L-1 follow on
//    consecutive cycles, one per cycle; dvld falls the cycle after byte L-1. No gaps inside a frame.
//  Timestamp = ts_ctr value in the cycle ack=1, registered for bytes 18-21.
//  ack outside WAIT_ACK is ignored.
//  FSM:
//   IDLE     : gen_en=1 -> WAIT_ACK; clear gen_frames_sent and seq on entry from DONE/reset.
//   WAIT_ACK : dvld=1, data=DA[47:40]; on ack -> SEND (byte idx=1).
//   SEND     : idx++ each cycle; at idx=L-1 -> IFG; seq++ and gen_frames_sent++ on the last byte.
//   IFG      : dvld=0 for gen_ifg cycles (0 = next frame starts next cycle).
//              Then: gen_count!=0 and frames_sent==gen_count -> DONE.
//              Else gen_en=1 -> WAIT_ACK. Else -> IDLE.
//   DONE     : gen_done=1; gen_en=0 -> IDLE (counters hold until the next run starts).
//  gen_en deassert mid-frame: the current frame completes in full, then IFG, then IDLE.
//  seq: 32b, wraps to 0; first frame of a run carries seq=0.
//  gen_frames_sent saturates at 2^32-1 in continuous mode.
// CONFIGURATION
//  GEN_PRBS_PAYLOAD_EN defined: pad bytes (idx>=22) come from PRBS-7 (x^7+x^6+1), seed 7'h7F.
//   Reseeded at each frame start; one 8-bit step per pad byte; byte = LFSR state after 8 shifts.
//  Not defined: pad bytes are 0x00 and no LFSR is synthesised.
// TESTING
//  T1 reset: reset=1 mid-frame -> dvld, data, busy, done, frames_sent = 0 the same cycle; after release, IDLE.
//  T2 gen_len=64, gen_count=1, ack 3 cycles after dvld:
//     data held at 0xFF until ack; 64 bytes total, bytes 12-13 = 88 B5, 14-17 = 00 00 00 00;
//     done=1, frames_sent=1.
//  T3 gen_len=20 and gen_len=2000 -> 60 and 1514 bytes per frame respectively.
//  T4 gen_count=3, gen_ifg=12 -> 3 frames, seq 0,1,2, exactly 12 dvld-low cycles between frames,
//     timestamps strictly increasing and equal to ts_ctr at each ack.
//  T5 gen_count=0, drop gen_en at byte 30 of frame 5 -> frame 5 completes its full L bytes, then IDLE, no frame 6.
//  T6 GEN_PRBS_PAYLOAD_EN defined: pad bytes match the reference PRBS-7 model, identical in every frame;
//     without the macro all pad bytes are 0x00.

Source files
------------

// File: rtl/gig_eth_tx_frame_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gig_eth_tx_frame_gen_if : MAC TX client byte stream (data/valid/ack)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface gig_eth_tx_frame_gen_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_underrun;
  logic       mac_tx_ack;

  modport master (
    output mac_tx_data,
    output mac_tx_dvld,
    output mac_tx_underrun,
    input  mac_tx_ack
  );

  modport slave (
    input  mac_tx_data,
    input  mac_tx_dvld,
    input  mac_tx_underrun,
    output mac_tx_ack
  );
endinterface
`default_nettype wire

// File: rtl/gig_eth_tx_frame_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gig_eth_tx_frame_gen : delay-measurement test-frame source for the MAC TX port
//   (DA | SA | EtherType | seq | timestamp | pad). Option: GEN_PRBS_PAYLOAD_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gig_eth_tx_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          MIN_LEN   = 60,
  parameter int          MAX_LEN   = 1514
) (
  input  wire logic                  tx_clk,
  input  wire logic                  reset,
  input  wire logic                  gen_en,
  input  wire logic [13:0]           gen_len,
  input  wire logic [15:0]           gen_ifg,
  input  wire logic [31:0]           gen_count,
  gig_eth_tx_frame_gen_if.master     mac,
  output logic                       gen_busy,
  output logic                       gen_done,
  output logic [31:0]                gen_frames_sent
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WAIT_ACK = 3'd1;
  localparam logic [2:0] c_SEND     = 3'd2;
  localparam logic [2:0] c_IFG      = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  localparam logic [10:0] c_MIN_LEN = 11'(MIN_LEN);
  localparam logic [10:0] c_MAX_LEN = 11'(MAX_LEN);
  localparam logic [10:0] c_PAD_IDX = 11'd22;

  logic [2:0]   state_q, state_d;
  logic [10:0]  idx_q, idx_d;
  logic [10:0]  len_q, len_d;
  logic [15:0]  ifg_q, ifg_d;
  logic [31:0]  seq_q, seq_d;
  logic [31:0]  frames_q, frames_d;
  logic [31:0]  ts_ctr_q;
  logic [31:0]  ts_q, ts_d;
  logic         clr_pend_q, clr_pend_d;

  logic [10:0]  w_len_clamped;
  logic [31:0]  w_frames_inc;
  logic [31:0]  w_frames_chk;
  logic         w_last;
  logic         w_dvld;
  logic [7:0]   w_pad;
  logic [7:0]   w_data;
  logic [175:0] w_hdr;
  logic [4:0]   w_hidx;

  always_comb begin
    w_len_clamped = gen_len[10:0];
    if (gen_len < 14'(MIN_LEN)) begin
      w_len_clamped = c_MIN_LEN;
    end else if (gen_len > 14'(MAX_LEN)) begin
      w_len_clamped = c_MAX_LEN;
    end
  end

  assign w_frames_inc = (frames_q == 32'hFFFF_FFFF) ? frames_q : frames_q + 32'd1;
  // The run-end test in SEND (zero IFG) must see the count including this frame.
  assign w_frames_chk = (state_q == c_SEND) ? w_frames_inc : frames_q;
  assign w_last       = (idx_q == len_q - 11'd1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    ifg_d      = ifg_q;
    seq_d      = seq_q;
    frames_d   = frames_q;
    ts_d       = ts_q;
    clr_pend_d = clr_pend_q;

    case (state_q)
      c_IDLE: begin
        if (gen_en) begin
          state_d = c_WAIT_ACK;
          len_d   = w_len_clamped;
          idx_d   = '0;
          if (clr_pend_q) begin
            seq_d      = '0;
            frames_d   = '0;
            clr_pend_d = 1'b0;
          end
        end
      end
      c_WAIT_ACK: begin
        if (mac.mac_tx_ack) begin
          ts_d    = ts_ctr_q;
          idx_d   = 11'd1;
          state_d = c_SEND;
        end
      end
      c_SEND, c_IFG: begin
        if (state_q == c_SEND) begin
          idx_d = idx_q + 11'd1;
        end else begin
          ifg_d = ifg_q - 16'd1;
        end
        if ((state_q == c_SEND && w_last) || (state_q == c_IFG && ifg_q <= 16'd1)) begin
          if (state_q == c_SEND) begin
            seq_d    = seq_q + 32'd1;
            frames_d = w_frames_inc;
          end
          if (state_q == c_SEND && gen_ifg != 16'd0) begin
            ifg_d   = gen_ifg;
            state_d = c_IFG;
          end else if (gen_count != 32'd0 && w_frames_chk == gen_count) begin
            state_d = c_DONE;
          end else if (gen_en) begin
            state_d = c_WAIT_ACK;
            len_d   = w_len_clamped;
            idx_d   = '0;
          end else begin
            state_d = c_IDLE;
          end
        end
      end
      c_DONE: begin
        if (!gen_en) begin
          state_d    = c_IDLE;
          clr_pend_d = 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_IDLE;
      idx_q      <= '0;
      len_q      <= c_MIN_LEN;
      ifg_q      <= '0;
      seq_q      <= '0;
      frames_q   <= '0;
      ts_ctr_q   <= '0;
      ts_q       <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      ifg_q      <= ifg_d;
      seq_q      <= seq_d;
      frames_q   <= frames_d;
      ts_ctr_q   <= ts_ctr_q + 32'd1;
      ts_q       <= ts_d;
      clr_pend_q <= clr_pend_d;
    end
  end

`ifdef GEN_PRBS_PAYLOAD_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] w_prbs_state;
  logic [7:0] w_prbs_byte;
  logic       w_prbs_bit;

  // Each pad byte is the eight x^7+x^6+1 output bits of one step, earliest bit in the MSB.
  always_comb begin
    w_prbs_state = lfsr_q;
    w_prbs_byte  = '0;
    w_prbs_bit   = 1'b0;
    for (int b = 0; b < 8; b++) begin
      w_prbs_bit   = w_prbs_state[6] ^ w_prbs_state[5];
      w_prbs_byte  = {w_prbs_byte[6:0], w_prbs_bit};
      w_prbs_state = {w_prbs_state[5:0], w_prbs_bit};
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == c_WAIT_ACK) begin
      lfsr_d = 7'h7F;
    end else if (state_q == c_SEND && idx_q >= c_PAD_IDX) begin
      lfsr_d = w_prbs_state;
    end
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 7'h7F;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign w_pad = w_prbs_byte;
`else
  assign w_pad = 8'h00;
`endif

  assign w_dvld = (state_q == c_WAIT_ACK) || (state_q == c_SEND);
  assign w_hdr  = {DST_MAC, SRC_MAC, ETHERTYPE, seq_q, ts_q};
  assign w_hidx = 5'd21 - idx_q[4:0];

  always_comb begin
    w_data = 8'h00;
    if (w_dvld) begin
      if (idx_q < c_PAD_IDX) begin
        w_data = w_hdr[{w_hidx, 3'b000} +: 8];
      end else begin
        w_data = w_pad;
      end
    end
  end

  assign mac.mac_tx_data     = w_data;
  assign mac.mac_tx_dvld     = w_dvld;
  assign mac.mac_tx_underrun = 1'b0;
  assign gen_busy            = (state_q != c_IDLE) && (state_q != c_DONE);
  assign gen_done            = (state_q == c_DONE);
  assign gen_frames_sent     = frames_q;

endmodule
`default_nettype wire
